// File: rtl/inv_sub_column.sv
// Column-serial inverse S-box stage: inverts LANES nibbles of a 64-bit state per clock.
// Valid/ready on both sides; one block in flight at a time.
module inv_sub_column #(
  parameter int LANES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] in_state,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [63:0] out_state,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int PASSES = 16 / LANES;
  localparam int CNT_W  = $clog2(PASSES + 1);
  localparam logic [CNT_W-1:0] LAST_PASS = CNT_W'(PASSES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_pass, w_pass_next;
  logic [63:0]      r_work, w_work_next, w_sub;

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h9;  4'h1: y = 4'h4;  4'h2: y = 4'hF;  4'h3: y = 4'hA;
      4'h4: y = 4'hE;  4'h5: y = 4'h1;  4'h6: y = 4'h0;  4'h7: y = 4'h6;
      4'h8: y = 4'hC;  4'h9: y = 4'h7;  4'hA: y = 4'h3;  4'hB: y = 4'h8;
      4'hC: y = 4'h2;  4'hD: y = 4'hB;  4'hE: y = 4'h5;  default: y = 4'hD;
    endcase
    return y;
  endfunction

  // Each nibble belongs to exactly one pass; only that pass rewrites it.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_nib
      localparam logic [CNT_W-1:0] PASS_IDX = CNT_W'(gi / LANES);
      assign w_sub[4*gi +: 4] = (r_pass == PASS_IDX) ? inv_sbox(r_work[4*gi +: 4])
                                                     : r_work[4*gi +: 4];
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    w_pass_next  = r_pass;
    w_work_next  = r_work;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_state_next = BUSY;
          w_pass_next  = '0;
          w_work_next  = in_state;
        end
      end
      BUSY: begin
        w_work_next = w_sub;
        if (r_pass == LAST_PASS) begin
          w_state_next = DONE;
        end else begin
          w_pass_next = r_pass + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_pass  <= '0;
      r_work  <= 64'h0;
    end else begin
      r_state <= w_state_next;
      r_pass  <= w_pass_next;
      r_work  <= w_work_next;
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign out_state = r_work;

endmodule
